// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter (and the matching receiver).
// Holds the parity modes, the shifter state encoding and the frame length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Clock cycles for one complete frame, start bit through the last stop bit.
  function automatic int frame_clks(input int data_bits, input int clks_per_bit,
                                    input int parity, input int stop_bits);
    int parity_bits;
    parity_bits = (parity != PARITY_NONE) ? 1 : 0;
    return (1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART shifter; dout is the word at the
// read pointer, available combinationally so the shifter can pop and latch it.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap naturally at DEPTH; the count's extra bit tells full from empty.
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: FIFO-buffered words serialised LSB first with start bit,
// optional parity and one or two stop bits; queued frames run back-to-back.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          pin,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import uart_pkg::*;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 pin_reg, pin_next;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 frame_parity;

  assign ready     = !fifo_full;
  assign fifo_push = valid && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Parity is fixed when the word is popped so it never tracks later data changes.
  assign frame_parity = (PARITY == PARITY_ODD) ? ~(^fifo_dout) : (^fifo_dout);
  assign bit_end      = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = bit_end ? '0 : cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pin_next   = 1'b1;
    fifo_pop   = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        fifo_pop = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == DATA_LAST) begin
            idx_next   = '0;
            state_next = HAS_PARITY ? uart_pkg::PARITY : STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          idx_next   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_reg == STOP_LAST) begin
            done       = 1'b1;
            state_next = IDLE;
            fifo_pop   = !fifo_empty;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A pop always starts a fresh frame, either from idle or straight out of STOP.
    if (fifo_pop) begin
      state_next = START;
      cnt_next   = '0;
      idx_next   = '0;
      shift_next = fifo_dout;
      par_next   = frame_parity;
    end

    case (state_next)
      START:            pin_next = 1'b0;
      DATA:             pin_next = shift_next[0];
      uart_pkg::PARITY: pin_next = par_next;
      default:          pin_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      pin_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      pin_reg   <= pin_next;
    end
  end

  assign pin  = pin_reg;
  assign busy = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of single frames over four frame
// formats, plus back-to-back, FIFO-full and mid-frame reset sequences.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: 8N1, 4 clk/bit   E: 8E1, 2 clk/bit   O: 8O1, 2 clk/bit   S: 7N2, 1 clk/bit
  logic [7:0] a_data, e_data, o_data;
  logic [6:0] s_data;
  logic a_valid, e_valid, o_valid, s_valid;
  logic a_ready, e_ready, o_ready, s_ready;
  logic a_pin, e_pin, o_pin, s_pin;
  logic a_busy, e_busy, o_busy, s_busy;
  logic a_done, e_done, o_done, s_done;
  logic [2:0] a_count, e_count, o_count, s_count;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .data(a_data), .valid(a_valid), .ready(a_ready),
    .pin(a_pin), .busy(a_busy), .done(a_done), .fifo_count(a_count));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(2), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst_n(rst_n), .data(e_data), .valid(e_valid), .ready(e_ready),
    .pin(e_pin), .busy(e_busy), .done(e_done), .fifo_count(e_count));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .rst_n(rst_n), .data(o_data), .valid(o_valid), .ready(o_ready),
    .pin(o_pin), .busy(o_busy), .done(o_done), .fifo_count(o_count));
  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
    .clk(clk), .rst_n(rst_n), .data(s_data), .valid(s_valid), .ready(s_ready),
    .pin(s_pin), .busy(s_busy), .done(s_done), .fifo_count(s_count));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         inst;
    logic [8:0] word;
    int         nbits;
    int         cpb;
    logic [0:15] seq;   // line bits in transmit order, leftmost first
  } vec_t;

  vec_t vecs [9];
  logic cap [0:255];
  int done_q [$];
  logic [7:0] exp_w [0:7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic pin_of(input int k);
    case (k)
      0: return a_pin;
      1: return e_pin;
      2: return o_pin;
      default: return s_pin;
    endcase
  endfunction

  function automatic logic done_of(input int k);
    case (k)
      0: return a_done;
      1: return e_done;
      2: return o_done;
      default: return s_done;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0: return a_busy;
      1: return e_busy;
      2: return o_busy;
      default: return s_busy;
    endcase
  endfunction

  task automatic drive(input int k, input logic [8:0] w, input logic v);
    case (k)
      0: begin a_data = w[7:0]; a_valid = v; end
      1: begin e_data = w[7:0]; e_valid = v; end
      2: begin o_data = w[7:0]; o_valid = v; end
      default: begin s_data = w[6:0]; s_valid = v; end
    endcase
  endtask

  // Called at a negedge with the selected instance idle.
  task automatic run_frame(input vec_t v, input int id);
    int lat;
    int done_cnt;
    int done_t;
    logic got;
    drive(v.inst, v.word, 1'b1);
    step();
    drive(v.inst, v.word, 1'b0);
    lat = 0;
    while (pin_of(v.inst) == 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check($sformatf("v%0d start latency", id), lat, 1);
    done_cnt = 0;
    done_t = -1;
    for (int b = 0; b < v.nbits; b++) begin
      got = v.seq[b];
      for (int c = 0; c < v.cpb; c++) begin
        if (pin_of(v.inst) !== v.seq[b]) got = pin_of(v.inst);
        if (done_of(v.inst) === 1'b1) begin
          done_cnt++;
          done_t = b * v.cpb + c;
        end
        step();
      end
      check($sformatf("v%0d line bit %0d", id, b), int'(got), int'(v.seq[b]));
    end
    check($sformatf("v%0d done pulses", id), done_cnt, 1);
    check($sformatf("v%0d done cycle", id), done_t, v.nbits * v.cpb - 1);
    check($sformatf("v%0d pin idle after", id), int'(pin_of(v.inst)), 1);
    check($sformatf("v%0d busy after", id), int'(busy_of(v.inst)), 0);
    $display("vec %0d: inst %0d word 0x%0h, %0d bits x %0d clks, errors so far %0d",
             id, v.inst, v.word, v.nbits, v.cpb, errors);
  endtask

  task automatic sample(input int t);
    cap[t] = a_pin;
    if (a_done === 1'b1) done_q.push_back(t);
  endtask

  // Reference 8N1 line for exp_w[0..nw-1] at 4 clk/bit, frames contiguous.
  task automatic check_stream(input string tag, input int nw);
    int pos;
    logic expb;
    logic got;
    logic want;
    for (int f = 0; f < nw; f++) begin
      got = 1'b0;
      want = 1'b0;
      for (int t = f * 40; t < f * 40 + 40; t++) begin
        pos = (t % 40) / 4;
        if (pos == 0) expb = 1'b0;
        else if (pos == 9) expb = 1'b1;
        else expb = exp_w[f][pos-1];
        if (cap[t] !== expb && got == want) begin
          got = cap[t];
          want = expb;
          if (got == want) got = ~want;
        end
      end
      check($sformatf("%s frame %0d line", tag, f), int'(got), int'(want));
    end
    check($sformatf("%s done pulses", tag), done_q.size(), nw);
    for (int f = 0; f < nw; f++) begin
      check($sformatf("%s done time %0d", tag, f),
            (f < done_q.size()) ? done_q[f] : -1, f * 40 + 39);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    int done_seen;
    vecs[0] = '{0, 9'h0A5, 10, 4, 16'b0101001011_000000};
    vecs[1] = '{0, 9'h03C, 10, 4, 16'b0001111001_000000};
    vecs[2] = '{1, 9'h007, 11, 2, 16'b01110000011_00000};
    vecs[3] = '{2, 9'h007, 11, 2, 16'b01110000001_00000};
    vecs[4] = '{1, 9'h000, 11, 2, 16'b00000000001_00000};
    vecs[5] = '{2, 9'h000, 11, 2, 16'b00000000011_00000};
    vecs[6] = '{3, 9'h055, 10, 1, 16'b0101010111_000000};
    vecs[7] = '{3, 9'h07F, 10, 1, 16'b0111111111_000000};
    vecs[8] = '{0, 9'h0C3, 10, 4, 16'b0110000111_000000};

    a_data = '0; e_data = '0; o_data = '0; s_data = '0;
    a_valid = 0; e_valid = 0; o_valid = 0; s_valid = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset pin", int'(a_pin), 1);
    check("reset ready", int'(a_ready), 1);
    check("reset busy", int'(a_busy), 0);
    check("reset done", int'(a_done), 0);
    check("reset fifo_count", int'(a_count), 0);
    check("reset pin 7N2", int'(s_pin), 1);
    rst_n = 1'b1;
    step();
    check("idle pin after release", int'(a_pin), 1);
    $display("reset: errors so far %0d", errors);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Back-to-back frames
    done_q.delete();
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
    drive(0, 9'h011, 1'b1);
    step();
    check("b2b pin before pop", int'(a_pin), 1);
    check("b2b count after first push", int'(a_count), 1);
    a_data = 8'h22;
    step();
    sample(0);
    a_data = 8'h33;
    step();
    a_valid = 1'b0;
    check("b2b fifo_count", int'(a_count), 2);
    check("b2b busy", int'(a_busy), 1);
    for (int t = 1; t < 120; t++) begin
      sample(t);
      step();
    end
    check_stream("b2b", 3);
    check("b2b pin idle after", int'(a_pin), 1);
    check("b2b busy after", int'(a_busy), 0);
    $display("back-to-back 0x11 0x22 0x33: errors so far %0d", errors);

    // FIFO full: valid held 8 cycles with values 1..8
    done_q.delete();
    for (int i = 0; i < 8; i++) exp_w[i] = 8'(i + 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 9'(i), 1'b1);
      step();
      if (i >= 2) sample(i - 2);
      if (i == 4) check("full ready at 3 queued", int'(a_ready), 1);
      if (i == 5) begin
        check("full ready at 4 queued", int'(a_ready), 0);
        check("full count at 4 queued", int'(a_count), 4);
      end
    end
    a_valid = 1'b0;
    check("full count after hold", int'(a_count), 4);
    check("full ready after hold", int'(a_ready), 0);
    for (int t = 7; t < 200; t++) begin
      step();
      sample(t);
    end
    check_stream("full", 5);
    step();
    check("full busy after 5 frames", int'(a_busy), 0);
    check("full count after 5 frames", int'(a_count), 0);
    check("full pin after 5 frames", int'(a_pin), 1);
    $display("fifo full 1..8: errors so far %0d", errors);

    // Reset during data bit 3 of 0xA5 (bit 3 is 0), with 0x66 still queued
    drive(0, 9'h0A5, 1'b1);
    step();
    a_data = 8'h66;
    step();
    a_valid = 1'b0;
    repeat (17) step();
    check("pre-reset pin data bit 3", int'(a_pin), 0);
    check("pre-reset fifo_count", int'(a_count), 1);
    rst_n = 1'b0;
    #1;
    check("async reset pin", int'(a_pin), 1);
    check("async reset busy", int'(a_busy), 0);
    check("async reset fifo_count", int'(a_count), 0);
    check("async reset done", int'(a_done), 0);
    check("async reset ready", int'(a_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    done_seen = 0;
    for (int t = 0; t < 60; t++) begin
      if (a_pin === 1'b1) hi_cnt++;
      if (a_done === 1'b1) done_seen++;
      step();
    end
    check("post-reset line idle cycles", hi_cnt, 60);
    check("post-reset done pulses", done_seen, 0);
    $display("reset mid-frame: errors so far %0d", errors);

    run_frame(vecs[8], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter with a small input FIFO, an internal baud divider and configurable frame format (data width, parity, stop bits).
- Accepts words over a valid/ready handshake and serialises them LSB-first on a single idle-high line.
- Sends queued words back-to-back with no idle gap.
- Replaces the fixed 8N1, one-bit-per-clock transmitter in the serial subsystem.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clock cycles each line bit is held; must be >= 1.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data  input  DATA_BITS  word to transmit.
valid  input  1  data is presented this cycle.
ready  output  1  FIFO can accept a word (not full).
pin  output  1  serial TX line; idles high.
busy  output  1  frame in progress or FIFO non-empty.
done  output  1  one-cycle pulse in the last cycle of a frame's final stop bit.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pin=1, ready=1, busy=0, done=0, fifo_count=0.
  - FIFO flushed, shifter returns to IDLE.
  - Reset mid-frame aborts the frame; no partial-frame completion and no done pulse.
- Push: a word is written on any rising edge with valid && ready.
  - ready depends only on FIFO state, never on valid.
  - ready=0 when full, even if a pop happens in the same cycle.
  - valid while full is ignored; the word is dropped and state is unchanged.
- Pop: a word written at edge k is visible to the shifter in cycle k+1.
  - If the shifter is IDLE, the word is popped at edge k+1 and pin goes low from edge k+1.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - The popped word is latched into the shift register; later changes on data have no effect on it.
- Shifter states and hold times:
  - IDLE: pin=1.
  - START: pin=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
  - PARITY (only when PARITY!=0): held CLKS_PER_BIT cycles. Even = XOR of the data bits; odd = its inverse. Total count of ones over data+parity is even or odd accordingly.
  - STOP: pin=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, exact.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Bit advance happens when the counter reaches CLKS_PER_BIT-1.
  - Counter resets on every state entry.
  - CLKS_PER_BIT=1 gives one bit per clock.
- End of STOP:
  - done=1 in that final cycle.
  - If the FIFO is non-empty, pop and enter START at the same edge, so pin goes 1→0 with zero idle cycles.
  - Otherwise enter IDLE.
- busy = (state != IDLE) || (fifo_count != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by the extra count bit.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - shifter state encodings IDLE, START, DATA, PARITY, STOP;
  - a frame-length constant function of the parameters, shared with the future uart_rx_frame.
- Sub-module uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, din, dout, full, empty, count.
  - Combinational dout from the read pointer.
  - Same clk/rst_n convention as the top block.

Test Plan:
- 8N1, CLKS_PER_BIT=4: push 0xA5 once → pin = 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles; done pulses once, 40 cycles after pin first falls; then busy=0.
- PARITY=2 (even), then PARITY=1 (odd), DATA_BITS=8, CLKS_PER_BIT=2: send 0x07 → parity bit 1 (even) / 0 (odd); frame is 22 cycles.
- Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles (8N1, CLKS_PER_BIT=4) → three frames with no high cycle between stop and next start; done pulses spaced exactly 40 cycles apart.
- FIFO full, FIFO_DEPTH=4: hold valid for 8 cycles with values 1..8 → first word popped, 4 queued, ready=0, fifo_count=4; remaining words ignored; exactly words 1..5 are transmitted, in order.
- Reset mid-frame: assert rst_n=0 during data bit 3 → pin=1 immediately, busy=0, fifo_count=0, no done pulse; after release, a new push transmits normally.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=1: send 0x55 → 10-cycle frame; pin high for 2 cycles of stop; done in the second stop cycle.
